fetch_ctrl: RTL and testbench

//  Sequences the PC register and the instruction-side SRAM-like bus for the IF stage.

---
 rtl/fetch_ctrl_pkg.sv | 20 ++
 rtl/fetch_ctrl_if.sv | 19 +
 rtl/fetch_ctrl_redirect_sel.sv | 28 ++
 rtl/fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the IF-stage fetch controller: default vectors,
// FSM encoding and the sequential-PC helper.
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-side SRAM-like bus between the fetch controller (master)
// and instruction memory (slave).
interface fetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/fetch_ctrl_redirect_sel.sv
// Priority mux for PC redirects: exception > eret > branch.
// hard flags the redirects that squash the fetch in flight.
module redirect_sel
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic        br_taken,
  input  logic [31:0] epc,
  input  logic [31:0] br_target,
  output logic        redir,
  output logic        hard,
  output logic [31:0] redir_tgt
);

  always_comb begin
    redir     = exc_req | eret_req | br_taken;
    hard      = exc_req | eret_req;
    redir_tgt = br_target;
    if (exc_req)
      redir_tgt = EXC_VEC;
    else if (eret_req)
      redir_tgt = epc;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch controller: drives the PC register, issues one fetch at a
// time on the instruction bus and hands {pc, inst} to ID.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        pc_we,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  fetch_ctrl_if.master ibus,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  fetch_state_t state, state_nx;
  logic         pend_vld;
  logic [31:0]  pend_tgt;
  logic [31:0]  addr_q;
  logic         redir, hard;
  logic [31:0]  redir_tgt;
  logic         issue, resp, load;

  redirect_sel #(.EXC_VEC(EXC_VEC)) u_redirect_sel (
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .br_taken  (br_taken),
    .epc       (epc),
    .br_target (br_target),
    .redir     (redir),
    .hard      (hard),
    .redir_tgt (redir_tgt)
  );

  // A held, stalled slot blocks new requests so returning data is never lost.
  assign ibus.inst_req  = (state == S_REQ) && !(if_valid && stall) && !reset;
  assign ibus.inst_addr = pc_cur;

  assign issue = ibus.inst_req && ibus.inst_addr_ok;
  assign resp  = ibus.inst_data_ok && ((state == S_WAIT) || ((state == S_REQ) && issue));
  assign load  = resp && !stall && !hard;

  // A squash that coincides with the returning data discards it right away
  // and goes back to REQ, since DROP would wait for a response already seen.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: state_nx = S_REQ;
      S_REQ:
        if (issue) begin
          if (ibus.inst_data_ok) state_nx = S_REQ;
          else if (hard)         state_nx = S_DROP;
          else                   state_nx = S_WAIT;
        end
      S_WAIT:
        if (ibus.inst_data_ok) state_nx = S_REQ;
        else if (hard)         state_nx = S_DROP;
      S_DROP:
        if (ibus.inst_data_ok) state_nx = S_REQ;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    pc_we   = 1'b0;
    pc_next = seq_pc(pc_cur);
    if (reset) begin
      pc_next = RESET_PC;
    end else if (hard) begin
      pc_we   = 1'b1;
      pc_next = redir_tgt;
    end else if (state == S_IDLE) begin
      pc_we   = 1'b1;
      pc_next = RESET_PC;
    end else if (issue) begin
      pc_we   = 1'b1;
      if (redir)
        pc_next = redir_tgt;
      else if (pend_vld)
        pc_next = pend_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Branch target waits here until the delay-slot fetch is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend_tgt <= '0;
    end else if (hard || issue) begin
      pend_vld <= 1'b0;
    end else if (br_taken) begin
      pend_vld <= 1'b1;
      pend_tgt <= br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)      addr_q <= '0;
    else if (issue) addr_q <= pc_cur;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
    end else if (hard) begin
      if_valid <= 1'b0;
    end else if (load) begin
      if_valid <= 1'b1;
      if_pc    <= (state == S_REQ) ? pc_cur : addr_q;
      if_inst  <= ibus.inst_rdata;
    end else if (!stall) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl: a transaction-level model
// predicts fetch addresses and deliveries; a monitor checks what ID receives.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_cur, pc_next;
  logic        pc_we;
  logic        stall = 1'b0, br_taken = 1'b0, exc_req = 1'b0, eret_req = 1'b0;
  logic [31:0] br_target = '0, epc = '0;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;

  fetch_ctrl_if ibus();

  fetch_ctrl #(.RESET_PC(RST_PC), .EXC_VEC(EXC_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_cur    (pc_cur),
    .pc_next   (pc_next),
    .pc_we     (pc_we),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .ibus      (ibus),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst)
  );

  always #5 clk = ~clk;

  // The PC register the controller sequences; starts at 0 so the first load is visible.
  always @(posedge clk) begin
    if (reset)      pc_cur <= '0;
    else if (pc_we) pc_cur <= pc_next;
  end

  typedef struct {
    logic [31:0] addr;
    logic        stale;
    int unsigned rdy;
  } fetch_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } deliv_t;

  fetch_t      bus_q[$];
  deliv_t      exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  logic [31:0] exp_pc = RST_PC;
  logic        pend_v = 1'b0;
  logic [31:0] pend_t = '0;
  logic        rst_prev = 1'b0;
  logic        timed_out = 1'b0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0:       t = 32'h8000_1000;
      1:       t = 32'hFFFF_FFFC;
      default: t = {$urandom} & 32'hFFFF_FFFC;
    endcase
    return t;
  endfunction

  // Predict the effect of the upcoming clock edge from the stable inputs.
  task automatic step();
    logic        acc, hard;
    logic [31:0] htgt, nxt;
    fetch_t      f;
    cyc++;
    if (reset) begin
      if (rst_prev) begin
        chk("rst_inst_req", {31'd0, ibus.inst_req}, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
        chk("rst_pc_next", pc_next, RST_PC);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
      end
      bus_q.delete();
      exp_pc   = RST_PC;
      pend_v   = 1'b0;
      rst_prev = 1'b1;
      last_acc = cyc;
      return;
    end
    rst_prev = 1'b0;
    hard = exc_req || eret_req;
    htgt = exc_req ? EXC_PC : epc;
    acc  = ibus.inst_req && ibus.inst_addr_ok;

    if (ibus.inst_data_ok && bus_q.size() > 0) begin
      f = bus_q.pop_front();
      if (!f.stale && !stall && !hard)
        exp_q.push_back('{f.addr, mem(f.addr)});
    end

    if (acc) begin
      chk("fetch_addr", ibus.inst_addr, exp_pc);
      bus_q.push_back('{ibus.inst_addr, 1'b0, cyc + $urandom_range(0, 2)});
      last_acc = cyc;
    end

    if (hard) begin
      chk("redir_pc_we", {31'd0, pc_we}, 32'd1);
      chk("redir_pc_next", pc_next, htgt);
      foreach (bus_q[i]) bus_q[i].stale = 1'b1;
      exp_pc = htgt;
      pend_v = 1'b0;
    end else if (acc) begin
      nxt = br_taken ? br_target : (pend_v ? pend_t : exp_pc + 32'd4);
      chk("issue_pc_we", {31'd0, pc_we}, 32'd1);
      chk("issue_pc_next", pc_next, nxt);
      exp_pc = nxt;
      pend_v = 1'b0;
    end else if (br_taken) begin
      pend_v = 1'b1;
      pend_t = br_target;
    end

    if (cyc - last_acc > 300) begin
      checks++;
      errors++;
      timed_out = 1'b1;
      $display("FAIL fetch_timeout actual=no_request required=request_within_300_cycles");
    end
  endtask

  task automatic drive(input int stall_pct, input int br_pct, input int exc_pct,
                       input int eret_pct, input int aok_pct);
    stall     = ($urandom_range(0, 99) < stall_pct);
    br_taken  = ($urandom_range(0, 99) < br_pct);
    exc_req   = ($urandom_range(0, 99) < exc_pct);
    eret_req  = ($urandom_range(0, 99) < eret_pct);
    br_target = pick_target();
    epc       = pick_target();
    ibus.inst_addr_ok = ($urandom_range(0, 99) < aok_pct);
    if (bus_q.size() > 0) begin
      ibus.inst_data_ok = (bus_q[0].rdy <= cyc);
      ibus.inst_rdata   = mem(bus_q[0].addr);
    end else begin
      // Stray response with nothing outstanding; must be ignored.
      ibus.inst_data_ok = !ibus.inst_addr_ok && ($urandom_range(0, 9) == 0);
      ibus.inst_rdata   = $urandom;
    end
  endtask

  task automatic run(input int n, input int stall_pct, input int br_pct, input int exc_pct,
                     input int eret_pct, input int aok_pct);
    for (int i = 0; i < n && !timed_out; i++) begin
      @(negedge clk);
      step();
      @(posedge clk);
      #1;
      drive(stall_pct, br_pct, exc_pct, eret_pct, aok_pct);
    end
  endtask

  // Monitor: each fresh if_valid presentation must match the oldest prediction.
  logic prev_v = 1'b0, prev_s = 1'b0;
  always @(negedge clk) begin
    deliv_t d;
    if (if_valid === 1'b1 && !(prev_v && prev_s)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery actual=pc_%h required=no_delivery", if_pc);
      end else begin
        d = exp_q.pop_front();
        delivered++;
        chk("if_pc", if_pc, d.pc);
        chk("if_inst", if_inst, d.inst);
      end
    end
    if (if_valid === 1'b1 && stall === 1'b1)
      chk("no_req_while_held", {31'd0, ibus.inst_req}, 32'd0);
    prev_v = (if_valid === 1'b1);
    prev_s = (stall === 1'b1);
  end

  initial begin
    ibus.inst_addr_ok = 1'b0;
    ibus.inst_data_ok = 1'b0;
    ibus.inst_rdata   = '0;
    reset = 1'b1;
    run(3, 0, 0, 0, 0, 100);
    reset = 1'b0;
    run(40, 0, 0, 0, 0, 100);
    run(200, 25, 0, 0, 0, 80);
    run(3000, 20, 6, 2, 2, 70);
    reset = 1'b1;
    run(3, 0, 0, 0, 0, 100);
    reset = 1'b0;
    run(1500, 30, 15, 8, 8, 60);
    run(30, 0, 0, 0, 0, 100);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL undelivered actual=%0d required=0", exp_q.size());
    end
    checks++;
    if (delivered < 200) begin
      errors++;
      $display("FAIL delivery_count actual=%0d required=at_least_200", delivered);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
